div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter_pkg.sv | 40 ++++
 rtl/div_step.sv | 46 ++++
 rtl/div_iter.sv | 201 ++++++++++++++++++++
 tb/tb_div_iter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter_pkg
//  Description : Shared types for the iterative divider. Holds the one-hot
//                divide opcode, its idle/reset value, the divider FSM state
//                encoding and small opcode decode helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package div_iter_pkg;

   // One-hot divide opcode; div occupies the MSB of the packed vector.
   typedef struct packed {
      logic div;
      logic divu;
      logic rem;
      logic remu;
   } div_op_type;

   localparam div_op_type init_div_op = '{div: 1'b0, divu: 1'b0, rem: 1'b0, remu: 1'b0};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIN  = 2'd2
   } div_state_t;

   function automatic logic div_op_signed(input div_op_type op);
      return op.div | op.rem;
   endfunction

   function automatic logic div_op_wants_rem(input div_op_type op);
      return op.rem | op.remu;
   endfunction

   function automatic logic div_op_wants_quo(input div_op_type op);
      return op.div | op.divu;
   endfunction

endpackage : div_iter_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : Combinational restoring-division step. Retires RADIX_BITS
//                quotient bits MSB-first per evaluation. The quotient register
//                doubles as the dividend shifter: its MSB feeds the partial
//                remainder and new quotient bits enter at the LSB.
//  Ports       : i_rem     - partial remainder in (always < i_divisor)
//                i_quo     - dividend-shift / quotient register in
//                i_divisor - divisor magnitude (nonzero)
//                o_rem     - partial remainder out
//                o_quo     - shift register out
//  Revision    : 1.0  initial release
// ============================================================================
module div_step #(
   parameter int XLEN       = 32,
   parameter int RADIX_BITS = 1
) (
   input  logic [XLEN-1:0] i_rem,
   input  logic [XLEN-1:0] i_quo,
   input  logic [XLEN-1:0] i_divisor,
   output logic [XLEN-1:0] o_rem,
   output logic [XLEN-1:0] o_quo
);

   // One extra bit: after the shift the remainder can reach 2*divisor-1.
   logic [XLEN:0]   w_rem;
   logic [XLEN-1:0] w_quo;

   always_comb begin
      w_rem = {1'b0, i_rem};
      w_quo = i_quo;
      for (int i = 0; i < RADIX_BITS; i++) begin
         w_rem = {w_rem[XLEN-1:0], w_quo[XLEN-1]};
         w_quo = {w_quo[XLEN-2:0], 1'b0};
         if (w_rem >= {1'b0, i_divisor}) begin
            w_rem    = w_rem - {1'b0, i_divisor};
            w_quo[0] = 1'b1;
         end
      end
      o_rem = w_rem[XLEN-1:0];
      o_quo = w_quo;
   end

endmodule : div_step
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter
//  Description : Multi-cycle signed/unsigned integer divider (div, divu, rem,
//                remu). Operates on operand magnitudes with a restoring
//                divider, then fixes the signs. Divide-by-zero, signed
//                overflow and (optionally) |dividend| < |divisor| finish in a
//                single cycle.
//  Ports       : clk    - clock, rising edge
//                rst    - synchronous active-high reset
//                enable - start request, honoured only in IDLE
//                op     - one-hot opcode {div, divu, rem, remu}
//                rdata1 - dividend
//                rdata2 - divisor
//                kill   - abort any in-flight operation
//                result - quotient or remainder, held until the next finish
//                ready  - one-cycle result-valid pulse
//  Revision    : 1.0  initial release
// ============================================================================
module div_iter
   import div_iter_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int RADIX_BITS = 1,
   parameter int EARLY_OUT  = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   input  div_op_type      op,
   input  logic [XLEN-1:0] rdata1,
   input  logic [XLEN-1:0] rdata2,
   input  logic            kill,
   output logic [XLEN-1:0] result,
   output logic            ready
);

   localparam int                c_iters = XLEN / RADIX_BITS;
   localparam int                c_cnt_w = (c_iters > 1) ? $clog2(c_iters) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_iters - 1);

   if ((RADIX_BITS != 1 && RADIX_BITS != 2 && RADIX_BITS != 4) ||
       (XLEN % RADIX_BITS != 0)) begin : g_bad_params
      $error("div_iter: RADIX_BITS must be 1, 2 or 4 and divide XLEN");
   end

   // ---------------------------------------------------------------- state
   div_state_t          r_state;
   div_state_t          w_state_nxt;
   div_op_type          r_op;
   logic                r_neg_q;
   logic                r_neg_r;
   logic [XLEN-1:0]     r_divisor;
   logic [XLEN-1:0]     r_rem;
   logic [XLEN-1:0]     r_quo;
   logic [c_cnt_w-1:0]  r_cnt;
   logic [XLEN-1:0]     r_result;
   logic                r_ready;

   // ------------------------------------------------------- operand decode
   logic            w_signed;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_a_mag;
   logic [XLEN-1:0] w_b_mag;
   logic            w_div_zero;
   logic            w_ovf;
   logic            w_early;
   logic            w_special;
   logic [XLEN-1:0] w_spec_quo;
   logic [XLEN-1:0] w_spec_rem;
   logic [XLEN-1:0] w_spec_result;

   assign w_signed   = div_op_signed(op);
   assign w_a_neg    = w_signed & rdata1[XLEN-1];
   assign w_b_neg    = w_signed & rdata2[XLEN-1];
   assign w_a_mag    = w_a_neg ? (-rdata1) : rdata1;
   assign w_b_mag    = w_b_neg ? (-rdata2) : rdata2;
   assign w_div_zero = (rdata2 == '0);
   assign w_ovf      = w_signed && (rdata1 == {1'b1, {(XLEN-1){1'b0}}}) && (rdata2 == '1);
   assign w_early    = (EARLY_OUT != 0) && !w_div_zero && (w_a_mag < w_b_mag);
   assign w_special  = w_div_zero | w_ovf | w_early;

   // Priority matters only for the quotient/remainder pairing; the three
   // cases cannot overlap except zero-divisor vs. nothing.
   always_comb begin
      w_spec_quo = '0;
      w_spec_rem = rdata1;
      if (w_div_zero) begin
         w_spec_quo = '1;
         w_spec_rem = rdata1;
      end else if (w_ovf) begin
         w_spec_quo = rdata1;
         w_spec_rem = '0;
      end
   end

   assign w_spec_result = ({XLEN{div_op_wants_quo(op)}} & w_spec_quo) |
                          ({XLEN{div_op_wants_rem(op)}} & w_spec_rem);

   // ------------------------------------------------------------ iteration
   logic [XLEN-1:0] w_step_rem;
   logic [XLEN-1:0] w_step_quo;
   logic [XLEN-1:0] w_calc_quo;
   logic [XLEN-1:0] w_calc_rem;
   logic [XLEN-1:0] w_calc_result;

   div_step #(
      .XLEN       (XLEN),
      .RADIX_BITS (RADIX_BITS)
   ) u_div_step (
      .i_rem     (r_rem),
      .i_quo     (r_quo),
      .i_divisor (r_divisor),
      .o_rem     (w_step_rem),
      .o_quo     (w_step_quo)
   );

   // Sign fix-up is applied to the step output so the final result is ready
   // on the same edge that enters FIN.
   assign w_calc_quo    = r_neg_q ? (-w_step_quo) : w_step_quo;
   assign w_calc_rem    = r_neg_r ? (-w_step_rem) : w_step_rem;
   assign w_calc_result = ({XLEN{div_op_wants_quo(r_op)}} & w_calc_quo) |
                          ({XLEN{div_op_wants_rem(r_op)}} & w_calc_rem);

   // ------------------------------------------------------ FSM: state reg
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ----------------------------------------------------- FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (enable) w_state_nxt = w_special ? ST_FIN : ST_CALC;
         ST_CALC: if (r_cnt == c_last) w_state_nxt = ST_FIN;
         ST_FIN:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
      if (kill) begin
         w_state_nxt = ST_IDLE;
      end
   end

   // --------------------------------------------------------- FSM: outputs
   logic            w_start;
   logic            w_iter;
   logic            w_finish;
   logic            w_ready_nxt;
   logic [XLEN-1:0] w_result_nxt;

   always_comb begin
      w_start      = (r_state == ST_IDLE) && enable && !kill;
      w_iter       = (r_state == ST_CALC);
      w_finish     = w_iter && (r_cnt == c_last) && !kill;
      w_ready_nxt  = (w_start && w_special) || w_finish;
      w_result_nxt = w_start ? w_spec_result : w_calc_result;
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op      <= init_div_op;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_divisor <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_cnt     <= '0;
         r_result  <= '0;
         r_ready   <= 1'b0;
      end else begin
         r_ready <= w_ready_nxt;
         if (w_ready_nxt) begin
            r_result <= w_result_nxt;
         end
         if (w_start) begin
            r_op      <= op;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_divisor <= w_b_mag;
            r_rem     <= '0;
            r_quo     <= w_a_mag;
            r_cnt     <= '0;
         end else if (w_iter) begin
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
            r_cnt <= r_cnt + c_cnt_w'(1);
         end
      end
   end

   assign result = r_result;
   assign ready  = r_ready;

endmodule : div_iter
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_iter
//  Description : Directed bench for div_iter. One instance at RADIX_BITS=1 and
//                one at RADIX_BITS=4 share operand/kill/reset inputs and have
//                separate enables. Expected results and latencies are queued
//                when an operation is launched and retired when ready pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_iter;
   import div_iter_pkg::*;

   localparam div_op_type OP_DIV  = div_op_type'(4'b1000);
   localparam div_op_type OP_DIVU = div_op_type'(4'b0100);
   localparam div_op_type OP_REM  = div_op_type'(4'b0010);
   localparam div_op_type OP_REMU = div_op_type'(4'b0001);

   logic        clk = 1'b0;
   logic        rst;
   logic        kill;
   logic        en1;
   logic        en4;
   div_op_type  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] res1;
   logic [31:0] res4;
   logic        rdy1;
   logic        rdy4;

   always #5 clk = ~clk;

   div_iter #(.XLEN(32), .RADIX_BITS(1), .EARLY_OUT(1)) u_dut1 (
      .clk(clk), .rst(rst), .enable(en1), .op(op), .rdata1(a), .rdata2(b),
      .kill(kill), .result(res1), .ready(rdy1)
   );

   div_iter #(.XLEN(32), .RADIX_BITS(4), .EARLY_OUT(1)) u_dut4 (
      .clk(clk), .rst(rst), .enable(en4), .op(op), .rdata1(a), .rdata2(b),
      .kill(kill), .result(res4), .ready(rdy4)
   );

   typedef struct {
      string       tag;
      logic [31:0] exp;
      int          lat;
   } sb_t;

   sb_t sb[$];
   int  n_checks = 0;
   int  n_err    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_en(input int which, input logic v);
      if (which == 4) en4 = v;
      else            en1 = v;
   endtask

   function automatic logic get_rdy(input int which);
      return (which == 4) ? rdy4 : rdy1;
   endfunction

   function automatic logic [31:0] get_res(input int which);
      return (which == 4) ? res4 : res1;
   endfunction

   function automatic logic [31:0] mag(input logic [31:0] v, input bit sgn);
      return (sgn && v[31]) ? (-v) : v;
   endfunction

   // Launch one operation, wait (bounded) for ready, check result, latency,
   // single-cycle pulse and result hold. With glitch set, enable is also
   // pulsed mid-CALC and during FIN with different operands.
   task automatic run_op(input int which, input div_op_type o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int lat,
                         input string tag, input bit glitch);
      sb_t  e;
      int   n;
      bit   seen;
      logic extra;
      sb.push_back('{tag, exp, lat});
      op = o;
      a  = x;
      b  = y;
      set_en(which, 1'b1);
      step();
      set_en(which, 1'b0);
      n    = 1;
      seen = 1'b0;
      while (n <= 60 && !seen) begin
         if (get_rdy(which)) begin
            seen = 1'b1;
         end else begin
            if (glitch && n == 10) begin
               a = ~x;
               b = 32'd1;
               set_en(which, 1'b1);
            end
            step();
            set_en(which, 1'b0);
            n++;
         end
      end
      e = sb.pop_front();
      check({e.tag, "/lat"}, 32'(n), 32'(e.lat));
      check({e.tag, "/result"}, get_res(which), e.exp);
      if (seen) begin
         if (glitch) begin
            a = ~x;
            b = 32'd1;
            set_en(which, 1'b1);
         end
         step();
         set_en(which, 1'b0);
         check({e.tag, "/pulse"}, {31'd0, get_rdy(which)}, 32'd0);
         extra = 1'b0;
         for (int k = 0; k < 3; k++) begin
            step();
            extra = extra | get_rdy(which);
         end
         check({e.tag, "/hold"}, get_res(which), e.exp);
         if (glitch) check({e.tag, "/no_restart"}, {31'd0, extra}, 32'd0);
      end
   endtask

   initial begin
      logic [31:0] x;
      logic [31:0] y;
      logic        any;
      rst  = 1'b1;
      kill = 1'b0;
      en1  = 1'b0;
      en4  = 1'b0;
      op   = init_div_op;
      a    = '0;
      b    = '0;
      step();
      step();
      check("reset/rdy1", {31'd0, rdy1}, 32'd0);
      check("reset/res1", res1, 32'd0);
      check("reset/rdy4", {31'd0, rdy4}, 32'd0);
      check("reset/res4", res4, 32'd0);
      rst = 1'b0;
      step();

      // Normal-latency operations, radix 2
      run_op(1, OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu100_7", 1'b0);
      run_op(1, OP_REMU, 32'd100, 32'd7, 32'd2, 33, "remu100_7", 1'b0);
      run_op(1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div-7_2", 1'b0);
      run_op(1, OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem-7_2", 1'b0);
      run_op(1, OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, "div100_-7", 1'b0);
      run_op(1, OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, "rem-100_7", 1'b0);

      // Single-cycle special cases
      run_op(1, OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu5_0", 1'b0);
      run_op(1, OP_REMU, 32'd5, 32'd0, 32'd5, 1, "remu5_0", 1'b0);
      run_op(1, OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, "rem-7_0", 1'b0);
      run_op(1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf", 1'b0);
      run_op(1, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf", 1'b0);
      run_op(1, OP_DIVU, 32'd3, 32'd10, 32'd0, 1, "early_divu", 1'b0);
      run_op(1, OP_REM, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, 1, "early_rem", 1'b0);

      // Radix 16
      run_op(4, OP_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 9, "r4_divu", 1'b0);
      run_op(4, OP_DIVU, 32'd3, 32'd10, 32'd0, 1, "r4_early", 1'b0);
      run_op(4, OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 9, "r4_rem", 1'b0);
      run_op(4, OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 9, "r4_remu", 1'b0);

      // Enable during CALC and FIN must not disturb anything
      run_op(1, OP_DIVU, 32'd1000, 32'd9, 32'd111, 33, "glitch", 1'b1);

      // Pseudo-random operands checked against the language's operators
      for (int i = 0; i < 4; i++) begin
         x = $urandom;
         y = ($urandom >> (i * 7)) | 32'd1;
         run_op(1, OP_DIVU, x, y, x / y, (x < y) ? 1 : 33, $sformatf("rnd%0d/divu", i), 1'b0);
         run_op(4, OP_REMU, x, y, x % y, (x < y) ? 1 : 9, $sformatf("rnd%0d/remu", i), 1'b0);
         if (i[0]) y = -y;
         run_op(1, OP_DIV, x, y, 32'($signed(x) / $signed(y)),
                (mag(x, 1'b1) < mag(y, 1'b1)) ? 1 : 33, $sformatf("rnd%0d/div", i), 1'b0);
         run_op(4, OP_REM, x, y, 32'($signed(x) % $signed(y)),
                (mag(x, 1'b1) < mag(y, 1'b1)) ? 1 : 9, $sformatf("rnd%0d/rem", i), 1'b0);
      end

      // Kill at T+5 of a long operation, restart at T+7
      op  = OP_DIVU;
      a   = 32'd1000;
      b   = 32'd3;
      en1 = 1'b1;
      step();
      en1 = 1'b0;
      any = 1'b0;
      for (int k = 0; k < 4; k++) begin
         any = any | rdy1;
         step();
      end
      kill = 1'b1;
      step();
      kill = 1'b0;
      any  = any | rdy1;
      check("kill/no_ready", {31'd0, any}, 32'd0);
      step();
      run_op(1, OP_DIVU, 32'd9, 32'd3, 32'd3, 33, "kill/next", 1'b0);

      // kill together with enable starts nothing (divisor zero would
      // otherwise pulse ready on the next cycle)
      op   = OP_DIVU;
      a    = 32'd77;
      b    = 32'd0;
      en1  = 1'b1;
      kill = 1'b1;
      step();
      en1  = 1'b0;
      kill = 1'b0;
      any  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         any = any | rdy1;
         step();
      end
      check("kill_en/no_ready", {31'd0, any}, 32'd0);
      check("kill_en/res_held", res1, 32'd3);

      // Reset in the middle of CALC
      op  = OP_DIVU;
      a   = 32'd1000;
      b   = 32'd3;
      en1 = 1'b1;
      step();
      en1 = 1'b0;
      for (int k = 0; k < 9; k++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid/ready", {31'd0, rdy1}, 32'd0);
      check("rst_mid/result", res1, 32'd0);
      any = 1'b0;
      for (int k = 0; k < 30; k++) begin
         any = any | rdy1;
         step();
      end
      check("rst_mid/no_ready", {31'd0, any}, 32'd0);
      run_op(1, OP_DIVU, 32'd1000, 32'd3, 32'd333, 33, "rst_mid/next", 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_div_iter
`default_nettype wire
